uart_rx_sampler: RTL
====================

# uart_rx_sampler

Standalone UART receiver for the 8N1 serial link that carries the LFSR entropy stream at 3 Mbaud. It accepts bytes from a host, flags framing errors, and decodes a single-byte command into a one-cycle pulse. It replaces ad-hoc compare logic around the UART receive path and feeds `synchronous_reset_timer` as its reset request. Its sampling behaviour is the exact counterpart of the transmit side's bit timing.

## Interface
Parameters:
- `CLOCKFRQ`, 12000000: system clock frequency in Hz.
- `BAUDRATE`, 3000000: line rate in baud.
- `CMD_BYTE`, 8'h72: byte value that raises `cmd_hit`.

Derived constants:
- `CLKS_PER_BIT = CLOCKFRQ / BAUDRATE`; integer division is required to be exact, and `CLKS_PER_BIT` must be at least 4 (elaboration-time assertion).
- `HALF = CLKS_PER_BIT / 2`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input; asynchronous to `clk`; idle level 1.
- `rx_byte`  out  8  last correctly framed byte, held until the next good frame.
- `received`  out  1  one-cycle pulse; `rx_byte` is valid and newly updated in that cycle.
- `recv_error`  out  1  one-cycle pulse on a bad stop bit.
- `cmd_hit`  out  1  one-cycle pulse, coincident with `received`, when the new byte equals `CMD_BYTE`.
- `is_receiving`  out  1  high from start-bit detection until the frame ends.

## Operation
- `rx` passes through a 2-FF synchronizer to give `rx_s`. A third register, `rx_d`, holds the previous `rx_s` for edge detection.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - On `rx_d`=1 and `rx_s`=0 (falling edge), load the bit counter with `HALF`-1 and go to START.
  - `is_receiving` rises in the cycle after the edge.
- START: at counter 0, sample `rx_s`.
  - If 0: reload counter with `CLKS_PER_BIT`-1, clear the bit index, go to DATA.
  - If 1 (glitch): go to IDLE; no pulse is raised.
- DATA:
  - At each counter 0, shift `rx_s` into the shift register LSB-first and reload the counter.
  - After bit index 7, go to STOP.
- STOP: at counter 0, sample `rx_s`.
  - If 1: copy the shift register to `rx_byte`, pulse `received`, pulse `cmd_hit` if the byte matches, go to IDLE.
  - If 0: pulse `recv_error`, leave `rx_byte` unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. A break condition therefore yields exactly one error.
- Back-to-back frames: IDLE is entered in the cycle after the stop-bit sample, so a start edge arriving half a bit after the stop-bit centre is caught.
- Reset:
  - Asserting `rst_n`=0 at any time forces IDLE.
  - All outputs go to 0, the shift register clears, and the synchronizer flops are set to 1.
  - A frame in flight is discarded silently.
  - After reset release mid-frame, reception resumes only on a fresh falling edge, so a stuck-low line produces no frame.

## Timing
- Reset values: `rx_byte`=8'h00; `received`, `recv_error`, `cmd_hit`, `is_receiving` all 0.
- Let t0 be the `clk` edge at which the first synchronizer stage captures the start bit's 0.
  - `received` (or `recv_error`) asserts in the cycle beginning at edge t0 + 2 + `HALF` + 9·`CLKS_PER_BIT`.
  - At defaults this is t0+40.
- Sample points lie at the bit centres, ±1 clk of synchronizer uncertainty.
  - Tolerates ±(`HALF`-1)/(10·`CLKS_PER_BIT`) baud mismatch; ±2.5% at defaults.
- `is_receiving` falls in the same cycle that `received` or `recv_error` pulses. After a framing error, WAIT_IDLE keeps it low.
- All pulses last exactly one cycle. At most one of `received` and `recv_error` is high in any cycle.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_rx_state_t`.
  - Function `clks_per_bit(CLOCKFRQ, BAUDRATE)`.
  - Constant `UART_DATA_BITS` = 8.
  - The transmit side reuses the same function and constant.
- One sub-module, `sync_2ff`: 2-flop synchronizer with parameterised reset value (1 here), async active-low reset.
- Counter width is `$clog2(CLKS_PER_BIT)`; bit index is 3 bits.

## Test plan
- Frame 8'hA5 at 3 Mbaud after reset -> `received` pulses once at t0+40, `rx_byte`=8'hA5, `cmd_hit`=0, `recv_error`=0.
- Frame 8'h72 -> `received` and `cmd_hit` pulse in the same cycle, `rx_byte`=8'h72.
- Frame 8'h3C with stop bit 0, followed by line held low 30 clk and then high -> `recv_error` pulses exactly once; `rx_byte` keeps its previous value; the next good frame 8'h11 is received.
- Low glitch of 1 clk on idle line -> no pulse; `is_receiving` high for at most `HALF`+1 cycles, then 0.
- Three back-to-back frames 8'h00, 8'hFF, 8'h55, plus repeat at +2% and −2% baud -> three `received` pulses with the correct bytes in each case.
- `rst_n` pulsed low during bit 4 of a frame with `rx` still low -> all outputs 0; no pulse for the aborted frame; the following clean frame 8'h81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and bit timing helper.
package uart_pkg;

    // Data bits per frame; the transmit side uses the same value.
    localparam int unsigned UART_DATA_BITS = 8;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } uart_rx_state_t;

    // System clocks per serial bit. Callers must check that the division is exact.
    function automatic int unsigned clks_per_bit(input int unsigned clockfrq,
                                                 input int unsigned baudrate);
        return clockfrq / baudrate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic ResetValue = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Two back-to-back flops; both preset to the line's idle level during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= ResetValue;
            q      <= ResetValue;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: centre-samples each bit, flags bad stop bits and decodes one command byte.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKFRQ = 12000000,
    parameter int unsigned BAUDRATE = 3000000,
    parameter logic [7:0]  CMD_BYTE = 8'h72
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       received,
    output logic       recv_error,
    output logic       cmd_hit,
    output logic       is_receiving
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCKFRQ, BAUDRATE);
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    // Bit timing must be an exact, reasonably oversampled ratio.
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT * BAUDRATE != CLOCKFRQ) begin : g_bad_timing
        $fatal(1, "uart_rx_sampler: CLOCKFRQ/BAUDRATE must be an exact integer >= 4");
    end

    logic                      rx_s;
    logic                      rx_d_q;
    logic [1:0]                flush_q;
    logic                      armed;
    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]                rx_byte_q, rx_byte_d;
    logic                      received_q, received_d;
    logic                      recv_error_q, recv_error_d;
    logic                      cmd_hit_q, cmd_hit_d;
    logic                      cnt_zero;

    sync_2ff #(
        .ResetValue(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

    // Previous synchronized sample for falling-edge detection, plus a flush counter that
    // stays below 3 until rx_s and rx_d both hold real line samples rather than reset presets.
    // Without it a line stuck low across reset release would look like a fresh start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_d_q  <= 1'b1;
            flush_q <= 2'd0;
        end else begin
            rx_d_q <= rx_s;
            if (flush_q != 2'd3) begin
                flush_q <= flush_q + 2'd1;
            end
        end
    end

    assign armed    = (flush_q == 2'd3);
    assign cnt_zero = (cnt_q == '0);

    // FSM state, timing counters, data shift register and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_byte_q    <= '0;
            received_q   <= 1'b0;
            recv_error_q <= 1'b0;
            cmd_hit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            received_q   <= received_d;
            recv_error_q <= recv_error_d;
            cmd_hit_q    <= cmd_hit_d;
        end
    end

    // Next-state logic: half-bit delay to the start-bit centre, then one full bit per sample.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        received_d   = 1'b0;
        recv_error_d = 1'b0;
        cmd_hit_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (armed && rx_d_q && !rx_s) begin
                    cnt_d   = CNT_HALF;
                    state_d = StStart;
                end
            end

            StStart: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!rx_s) begin
                    cnt_d     = CNT_FULL;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    // Start bit gone by its centre: treat as a glitch.
                    state_d = StIdle;
                end
            end

            StData: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            StStop: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rx_s) begin
                    rx_byte_d  = shift_q;
                    received_d = 1'b1;
                    cmd_hit_d  = (shift_q == CMD_BYTE);
                    state_d    = StIdle;
                end else begin
                    // Bad stop bit: keep the last good byte, wait for the line to recover.
                    recv_error_d = 1'b1;
                    state_d      = StWaitIdle;
                end
            end

            StWaitIdle: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rx_byte      = rx_byte_q;
    assign received     = received_q;
    assign recv_error   = recv_error_q;
    assign cmd_hit      = cmd_hit_q;
    assign is_receiving = (state_q == StStart) || (state_q == StData) || (state_q == StStop);

endmodule
